// File: rtl/tl_bypass_sequencer_pkg.sv
// Shared types and defaults for the TL-UL bypass sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tl_bypass_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4,
    ABORT  = 3'd5
  } seq_state_t;

  localparam int   DEF_MAX_FLIGHT    = 4;
  localparam int   DEF_DRAIN_TIMEOUT = 1024;
  localparam int   DEF_SETTLE_CYCLES = 2;
  localparam logic DEF_RESET_BYPASS  = 1'b1;

  // Drain timer width; DRAIN_TIMEOUT values above 2**16 are not representable.
  localparam int   DRAIN_TMR_W       = 16;

  // Width needed to hold 0..max_flight outstanding transactions.
  function automatic int flight_w(input int max_flight);
    return $clog2(max_flight + 1);
  endfunction

endpackage

// File: rtl/tl_bypass_sequencer_flight_counter.sv
// Outstanding-transaction counter for single-beat TL requests.
// Latency: count updates one cycle after inc/dec.
// Backpressure: none; the caller must gate inc so count never passes MAX_COUNT.
//
// Ports: clock, reset (sync, active-low), inc (request issued), dec (response
// retired), count (outstanding), zero (count == 0).
module tl_flight_counter #(
  parameter int MAX_COUNT = 4,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

  // inc and dec together cancel; both ends saturate so a stray response
  // cannot wrap the counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != CNT_MAX) count <= count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

  // A response with nothing outstanding means the upstream accounting is broken.
  d_underflow_a: assert property (@(posedge clock) disable iff (!reset) !(dec && zero));

endmodule

// File: rtl/tl_bypass_sequencer.sv
// Sequences bypass-select changes on the TL-UL crossbar: drains A->D traffic, flips, settles, acks.
// Latency: with nothing in flight, done pulses SETTLE_CYCLES+2 cycles after request accept.
// Backpressure: A path is stalled whenever not IDLE or MAX_FLIGHT requests are outstanding.
//
// Ports: clock, reset (sync, active-low); req_valid/req_bypass/req_ready switch
// request; up_a_valid/up_a_ready upstream A; dn_a_valid/dn_a_ready crossbar A;
// d_fire crossbar D handshake; bypass select; busy/done/timeout status.
// Optional: define TL_BYPASS_SEQ_STATS_EN to add stat_switches, stat_aborts,
// stat_max_drain counters.
module tl_bypass_sequencer
  import tl_bypass_seq_pkg::*;
#(
  parameter int   MAX_FLIGHT    = DEF_MAX_FLIGHT,
  parameter int   DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
  parameter int   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter logic RESET_BYPASS  = DEF_RESET_BYPASS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_bypass,
  output logic        req_ready,
  input  logic        up_a_valid,
  output logic        up_a_ready,
  output logic        dn_a_valid,
  input  logic        dn_a_ready,
  input  logic        d_fire,
  output logic        bypass,
  output logic        busy,
  output logic        done,
  output logic        timeout
`ifdef TL_BYPASS_SEQ_STATS_EN
  ,
  output logic [15:0] stat_switches,
  output logic [7:0]  stat_aborts,
  output logic [15:0] stat_max_drain
`endif
);

  localparam int FLIGHT_W = flight_w(MAX_FLIGHT);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [DRAIN_TMR_W-1:0] TMO_LAST    = DRAIN_TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [SETTLE_W-1:0]    SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [FLIGHT_W-1:0]    FLIGHT_MAX  = FLIGHT_W'(MAX_FLIGHT);

  seq_state_t             state, state_nxt;
  logic                   target_bypass;
  logic [DRAIN_TMR_W-1:0] drain_tmr;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic [FLIGHT_W-1:0]    flight;
  logic                   flight_zero;
  logic                   gate_open;
  logic                   a_fire;
  logic                   req_fire;
  logic                   drain_expired;

  tl_flight_counter #(
    .MAX_COUNT (MAX_FLIGHT),
    .CNT_W     (FLIGHT_W)
  ) u_flight (
    .clock (clock),
    .reset (reset),
    .inc   (a_fire),
    .dec   (d_fire),
    .count (flight),
    .zero  (flight_zero)
  );

  // A traffic only flows while idle and below the outstanding limit, so a
  // request accepted this cycle still sees any A that fires alongside it.
  assign gate_open  = (state == IDLE) && (flight < FLIGHT_MAX);
  assign dn_a_valid = up_a_valid & gate_open;
  assign up_a_ready = dn_a_ready & gate_open;
  assign a_fire     = dn_a_valid & dn_a_ready;

  assign req_ready  = (state == IDLE);
  assign req_fire   = req_valid & req_ready;
  assign busy       = (state != IDLE);

  assign drain_expired = (DRAIN_TIMEOUT != 0) && (drain_tmr == TMO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_fire) state_nxt = (req_bypass == bypass) ? DONE : DRAIN;
      end
      DRAIN: begin
        // Quiescence wins over the timeout if both hold in the same cycle.
        if (flight_zero)        state_nxt = SWITCH;
        else if (drain_expired) state_nxt = ABORT;
      end
      SWITCH: state_nxt = SETTLE;
      SETTLE: begin
        if (settle_cnt == '0) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      bypass        <= RESET_BYPASS;
      target_bypass <= RESET_BYPASS;
      drain_tmr     <= '0;
      settle_cnt    <= '0;
      done          <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state   <= state_nxt;
      // done rises with the DONE state; timeout is taken from the ABORT state
      // so it lands on the cycle the FSM is back in IDLE.
      done    <= (state_nxt == DONE);
      timeout <= (state == ABORT);

      if (req_fire) begin
        target_bypass <= req_bypass;
        drain_tmr     <= '0;
      end

      if ((state == DRAIN) && (drain_tmr != '1)) drain_tmr <= drain_tmr + DRAIN_TMR_W'(1);

      // The only place the select ever moves.
      if (state == SWITCH) begin
        bypass     <= target_bypass;
        settle_cnt <= SETTLE_LOAD;
      end

      if ((state == SETTLE) && (settle_cnt != '0)) settle_cnt <= settle_cnt - SETTLE_W'(1);
    end
  end

`ifdef TL_BYPASS_SEQ_STATS_EN
  // Duration of the current DRAIN including this cycle, saturating.
  logic [15:0] drain_len;
  assign drain_len = (drain_tmr == '1) ? drain_tmr : drain_tmr + 16'd1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_switches  <= '0;
      stat_aborts    <= '0;
      stat_max_drain <= '0;
    end else begin
      if ((state == SETTLE) && (state_nxt == DONE)) stat_switches <= stat_switches + 16'd1;
      if ((state == DRAIN) && (state_nxt == ABORT) && (stat_aborts != 8'hFF))
        stat_aborts <= stat_aborts + 8'd1;
      if ((state == DRAIN) && (state_nxt != DRAIN) && (drain_len > stat_max_drain))
        stat_max_drain <= drain_len;
    end
  end
`endif

endmodule

// File: tb/tb_tl_bypass_sequencer.sv
// Self-checking bench for tl_bypass_sequencer against a cycle-count reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tl_bypass_sequencer;

  localparam int MAXF   = 4;
  localparam int TMO    = 16;
  localparam int SETTLE = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0, req_bypass = 1'b0;
  logic up_a_valid = 1'b0, dn_a_ready = 1'b0, d_fire = 1'b0;
  logic req_ready, up_a_ready, dn_a_valid, bypass, busy, done, timeout;
`ifdef TL_BYPASS_SEQ_STATS_EN
  logic [15:0] stat_switches;
  logic [7:0]  stat_aborts;
  logic [15:0] stat_max_drain;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding A count and the bypass value software last got.
  int m_flight = 0;
  bit m_bypass = 1'b1;
  int plan_d[$];

  always #5 clock = ~clock;

  tl_bypass_sequencer #(
    .MAX_FLIGHT    (MAXF),
    .DRAIN_TIMEOUT (TMO),
    .SETTLE_CYCLES (SETTLE),
    .RESET_BYPASS  (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_bypass (req_bypass),
    .req_ready  (req_ready),
    .up_a_valid (up_a_valid),
    .up_a_ready (up_a_ready),
    .dn_a_valid (dn_a_valid),
    .dn_a_ready (dn_a_ready),
    .d_fire     (d_fire),
    .bypass     (bypass),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
`ifdef TL_BYPASS_SEQ_STATS_EN
    ,
    .stat_switches  (stat_switches),
    .stat_aborts    (stat_aborts),
    .stat_max_drain (stat_max_drain)
`endif
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One idle cycle of A traffic; entered and left at posedge+1.
  task automatic a_cycle(input bit uv, input bit dr, input bit df);
    bit open, fire;
    up_a_valid = uv; dn_a_ready = dr; d_fire = df; req_valid = 1'b0;
    #2;
    open = (m_flight < MAXF);
    fire = uv & dr & open;
    chk("dn_a_valid", dn_a_valid, uv & open);
    chk("up_a_ready", up_a_ready, dr & open);
    chk("idle_req_ready", req_ready, 1'b1);
    if (fire && !df) m_flight++;
    else if (df && !fire && m_flight > 0) m_flight--;
    @(posedge clock); #1;
    up_a_valid = 1'b0; d_fire = 1'b0;
  endtask

  // Issue one switch request and follow it to completion.
  // mode 0: drain every outstanding D at random times; 1: withhold at least one D;
  // 2: deliver D responses at the cycles listed in plan_d.
  // Cycle n is the cycle after the n-th clock edge following accept.
  task automatic run_switch(input bit rb, input bit acc_a, input int mode);
    int fl, z, flip, dcyc, tocyc, endc, k, t;
    bit noop, fire, dn, last_c;
    int d_at[$];
    req_valid = 1'b1; req_bypass = rb; up_a_valid = acc_a; dn_a_ready = 1'b1; d_fire = 1'b0;
    #2;
    fire = acc_a && (m_flight < MAXF);
    chk("acc_req_ready", req_ready, 1'b1);
    chk("acc_busy", busy, 1'b0);
    chk("acc_dn_a_valid", dn_a_valid, fire);
    @(posedge clock); #1;
    req_valid = 1'b0; up_a_valid = 1'b0;
    fl = m_flight + (fire ? 1 : 0);
    m_flight = fl;
    noop = (rb == m_bypass);
    d_at = {};
    t = -1;
    if (!noop) begin
      if (mode == 2) d_at = plan_d;
      else begin
        k = (mode == 1 && fl > 0) ? int'($urandom_range(0, fl - 1)) : fl;
        for (int i = 0; i < k; i++) begin
          t += 1 + int'($urandom_range(0, 4));
          d_at.push_back(t);
        end
      end
    end
    if (noop) begin
      dcyc = 0; tocyc = -1; flip = -1; endc = 0;
    end else begin
      if (d_at.size() != fl) z = 1000;
      else if (fl == 0)      z = 0;
      else                   z = d_at[d_at.size() - 1] + 1;
      if (z >= TMO) begin
        dcyc = -1; tocyc = TMO + 1; flip = -1; endc = TMO;
      end else begin
        flip = z + 2; dcyc = z + 2 + SETTLE; tocyc = -1; endc = dcyc;
      end
    end
    for (int n = 0; n <= endc + 1; n++) begin
      dn = 1'b0;
      foreach (d_at[j]) if (d_at[j] == n) dn = 1'b1;
      last_c = (n == endc + 1);
      up_a_valid = last_c ? 1'b0 : 1'($urandom_range(0, 1));
      dn_a_ready = 1'b1;
      d_fire = dn;
      #2;
      chk("done", done, n == dcyc);
      chk("timeout", timeout, n == tocyc);
      chk("bypass", bypass, (flip >= 0 && n >= flip) ? rb : m_bypass);
      chk("busy", busy, n <= endc);
      chk("req_ready", req_ready, n > endc);
      chk("dn_a_valid_gated", dn_a_valid, 1'b0);
      if (last_c) chk("up_a_ready_reopen", up_a_ready, m_flight < MAXF);
      else        chk("up_a_ready_gated", up_a_ready, 1'b0);
      @(posedge clock); #1;
      if (dn) m_flight--;
    end
    d_fire = 1'b0; up_a_valid = 1'b0;
    if (flip >= 0) m_bypass = rb;
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clock);
    #1; dn_a_ready = 1'b1;
    #2;
    chk("rst_bypass", bypass, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_up_a_ready", up_a_ready, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;

    // Idle switch 1->0: flip at cycle 2, done at cycle 4
    run_switch(1'b0, 1'b0, 0);
    // No-op request
    run_switch(1'b0, 1'b0, 0);
    // Drain wait: three A outstanding, D at +5, +9, +12
    repeat (3) a_cycle(1'b1, 1'b1, 1'b0);
    plan_d = '{5, 9, 12};
    run_switch(1'b1, 1'b0, 2);
    // Timeout: one A outstanding, D withheld
    a_cycle(1'b1, 1'b1, 1'b0);
    run_switch(1'b0, 1'b0, 1);
    while (m_flight > 0) a_cycle(1'b0, 1'b1, 1'b1);
    // Request accepted together with an A fire
    run_switch(1'b1, 1'b1, 0);

    // Back-pressure at MAX_FLIGHT and simultaneous A/D
    repeat (4) a_cycle(1'b1, 1'b1, 1'b0);
    a_cycle(1'b1, 1'b1, 1'b0);
    a_cycle(1'b1, 1'b1, 1'b1);
    a_cycle(1'b1, 1'b1, 1'b0);
    a_cycle(1'b1, 1'b1, 1'b0);
    a_cycle(1'b0, 1'b1, 1'b1);
    a_cycle(1'b0, 1'b1, 1'b1);
    a_cycle(1'b1, 1'b1, 1'b1);
    a_cycle(1'b1, 1'b1, 1'b0);
    a_cycle(1'b1, 1'b1, 1'b0);
    a_cycle(1'b1, 1'b1, 1'b0);
    while (m_flight > 0) a_cycle(1'b0, 1'b1, 1'b1);

    // Randomized traffic and switches
    repeat (150)
      a_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              (m_flight > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    repeat (10) begin
      run_switch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
      repeat (6)
        a_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                (m_flight > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    // Reset mid-SETTLE
    while (m_flight > 0) a_cycle(1'b0, 1'b1, 1'b1);
    if (m_bypass == 1'b0) run_switch(1'b1, 1'b0, 0);
    req_valid = 1'b1; req_bypass = 1'b0;
    #2;
    chk("rs_req_ready", req_ready, 1'b1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    #2;
    chk("rs_settle_bypass", bypass, 1'b0);
    chk("rs_settle_busy", busy, 1'b1);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    m_bypass = 1'b1;
    for (int n = 0; n < 6; n++) begin
      #2;
      chk("rs_done", done, 1'b0);
      chk("rs_bypass", bypass, 1'b1);
      chk("rs_busy", busy, 1'b0);
      chk("rs_req_ready", req_ready, 1'b1);
      @(posedge clock); #1;
    end
    // Sequencer still works after the reset
    run_switch(1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_bypass_sequencer.md
Name: tl_bypass_sequencer

Overview:
- Sequences changes of the bypass select on the TL-UL bus-bypass crossbar. It sits between the config/software request interface and the crossbar's bypass input.
- Gates upstream A traffic and tracks outstanding A→D transactions. It only flips bypass once the bus is quiescent, then settles and acknowledges.
- Removes the need for the crossbar to stall mid-flight and gives software a clean done/timeout indication.

Parameters:
- MAX_FLIGHT, 4, max outstanding single-beat A requests; flight counter width = $clog2(MAX_FLIGHT+1)
- DRAIN_TIMEOUT, 1024, cycles allowed in DRAIN before abort; 0 disables the timeout
- SETTLE_CYCLES, 2, idle cycles held after the bypass flip before acknowledging (≥1)
- RESET_BYPASS, 1, bypass value after reset

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  switch request
- req_bypass  in  1  requested bypass value
- req_ready  out  1  request accepted when req_valid & req_ready
- up_a_valid  in  1  upstream A valid
- up_a_ready  out  1  upstream A ready
- dn_a_valid  out  1  A valid toward crossbar
- dn_a_ready  in  1  crossbar A ready
- d_fire  in  1  crossbar D handshake (in_d valid & ready), one per A
- bypass  out  1  drives crossbar bypass select
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on successful switch
- timeout  out  1  one-cycle pulse on drain abort

Behaviour:
- Reset (reset==0 at clock edge) values: state=IDLE, bypass=RESET_BYPASS, flight=0, busy=0, done=0, timeout=0.
- A-path gating:
  - dn_a_valid = up_a_valid & gate_open.
  - up_a_ready = dn_a_ready & gate_open.
  - gate_open = (state==IDLE) & (flight<MAX_FLIGHT).
- Flight counter:
  - +1 on a_fire (dn_a_valid & dn_a_ready); −1 on d_fire. Both in the same cycle → unchanged.
  - d_fire at flight==0 is an error: counter saturates at 0; flagged by the assertion.
  - Counter never exceeds MAX_FLIGHT, guaranteed by gating.
- req_ready = (state==IDLE).
- FSM:
  - IDLE: on req accept with req_bypass==bypass → DONE (no-op switch). Otherwise latch target → DRAIN and reset the drain timer.
  - DRAIN: gate closed. When flight==0 (registered value) → SWITCH. Else if DRAIN_TIMEOUT!=0 and timer==DRAIN_TIMEOUT−1 → ABORT. Timer increments each DRAIN cycle and saturates.
  - SWITCH: bypass<=target; settle counter loaded with SETTLE_CYCLES−1 → SETTLE.
  - SETTLE: gate closed; count down; at 0 → DONE.
  - DONE: done=1 for one cycle → IDLE.
  - ABORT: timeout=1 for one cycle, bypass unchanged → IDLE.
- Latency: request with flight==0 → done pulses SETTLE_CYCLES+2 cycles after acceptance.
- bypass changes only on the SWITCH→SETTLE edge. No A handshake can occur from req accept through DONE.
- A request accepted in the same cycle as an A fire: that A is counted, and DRAIN waits for its D.
- Reset mid-operation: immediate return to reset values; in-flight D responses after reset are not tracked.
- done and timeout are registered outputs.

Optional Feature:
- Macro TL_BYPASS_SEQ_STATS_EN.
- Defined: adds outputs stat_switches[15:0] (successful switches, wraps at 0xFFFF→0), stat_aborts[7:0] (saturates at 0xFF) and stat_max_drain[15:0] (largest DRAIN duration in cycles, saturating). All cleared by reset.
- Undefined: none of these ports or registers exist; behaviour is otherwise identical.

Decomposition:
- Package tl_bypass_seq_pkg: state enum (IDLE, DRAIN, SWITCH, SETTLE, DONE, ABORT), a flight-width function, and default parameter constants.
- One natural sub-module: tl_flight_counter (inc/dec/saturate, exposes count and zero flag), reusable by other TL adapters.
- The FSM and gating stay in the top module.

Test Plan:
- Idle switch: flight=0, bypass=1, req_bypass=0 with SETTLE_CYCLES=2 → bypass=0 after 2 cycles, done pulse at cycle 4 after accept, dn_a_valid=0 throughout.
- Drain wait: 3 A fires then req_bypass=0; D fires at +5, +9, +12 → bypass flips the cycle after flight reaches 0, no A fire during DRAIN, done follows.
- No-op: req_bypass equal to the current bypass → done pulses 1 cycle after accept, bypass untouched, no gating beyond that cycle.
- Timeout: DRAIN_TIMEOUT=16, one A outstanding, D withheld → timeout pulse 17 cycles after accept, bypass unchanged, req_ready=1 the next cycle.
- Back-pressure: MAX_FLIGHT=4, 4 A fires without D → up_a_ready=0 while up_a_valid=1. One d_fire → a single further A accepted. Simultaneous a_fire and d_fire at flight=2 → flight stays 2.
- Reset mid-SETTLE: reset low for one cycle → bypass=RESET_BYPASS, state IDLE, done never pulses.
